cpu_trace_capture: RTL and testbench
====================================

Name: cpu_trace_capture

Overview:
- Consumes the per-instruction debug outputs of the 16-bit single-cycle CPU: PC, decoded op/rs/rt/rd, ALU result and register write data.
- Packs each executed instruction into a 4-word trace record and buffers records in a FIFO.
- Drains records as a 16-bit valid/ready word stream to a host or log sink.
- Sits beside the CPU in bring-up and regression builds; it is the receiving end of the CPU debug bus.

Parameters:
- DEPTH, 16, FIFO depth in records; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- cap_en  in  1  capture enable.
- op  in  4  CPU opcode.
- rs  in  4  CPU source register 1.
- rt  in  4  CPU source register 2.
- rd  in  4  CPU destination register.
- currentAddress  in  16  CPU PC.
- result  in  16  CPU ALU result.
- WriteData  in  16  CPU register-file write data.
- out_data  out  16  trace word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word.
- out_last  out  1  current word is the last word of a record.
- fifo_level  out  ADDR_W+1  records currently in the FIFO.
- overflow_cnt  out  8  dropped records; saturates at 255.

Behaviour:
- Reset:
  - Asynchronous; asserting RESET clears state immediately.
  - out_valid=0, out_last=0, out_data=0, fifo_level=0, overflow_cnt=0.
  - FSM goes to IDLE; FIFO pointers go to 0; first_flag=1; last_pc=0.
  - A partially sent record is discarded.
- Capture rule: a record is captured on a rising edge when cap_en=1 and (first_flag=1 or currentAddress != last_pc).
  - While cap_en=1, last_pc<=currentAddress and first_flag<=0 every cycle, including cycles whose record is dropped.
  - cap_en=0 freezes last_pc and first_flag. Draining continues.
- Record layout:
  - w0 = currentAddress.
  - w1 = {op,rs,rt,rd}.
  - w2 = result.
  - w3 = WriteData.
- FIFO:
  - Push on capture when not full.
  - When full, the capture is dropped and overflow_cnt increments, saturating at 255.
  - A push and a pop on the same edge with the FIFO full is legal: the push succeeds and nothing is dropped.
  - Pointers wrap modulo DEPTH.
  - fifo_level counts 0..DEPTH.
- Serializer FSM:
  - IDLE: if FIFO not empty, load the head record into a holding register, pop, set idx=0, go to SEND.
  - SEND:
    - Drives out_valid=1, out_data=hold[idx], out_last=(idx==3).
    - out_data and out_last are held stable until the out_ready handshake.
    - On out_valid&&out_ready with idx<3: idx++.
    - On the handshake with idx==3: if the FIFO is not empty, load the next record, pop and set idx=0, staying in SEND with no bubble; otherwise go to IDLE.
- Latency: a capture on edge N sets the FIFO non-empty after N; the record is loaded at N+1; out_valid=1 after edge N+1.
- Capacity: DEPTH records in the FIFO plus 1 in the holding register.
- out_valid never deasserts without a handshake, except on RESET.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter is added; it resets to 0 and wraps 0xFFFF->0.
  - Its value at the capture edge is appended as w4.
  - Records are 5 words; out_last is asserted on idx==4.
  - FIFO width is 80 bits.
- Undefined: 4-word records as above, no counter logic.

Test Plan:
- Reset: assert RESET for 2 cycles -> out_valid=0, out_last=0, fifo_level=0, overflow_cnt=0; deassert with cap_en=0 -> outputs stay 0.
- Single record: cap_en=1 for one cycle with currentAddress=0x0004, op=1, rs=2, rt=3, rd=4, result=0x0007, WriteData=0x0007, out_ready=1 -> out_valid rises 2 edges after capture; words 0x0004, 0x1234, 0x0007, 0x0007; out_last only on the 4th word; then out_valid=0.
- Backpressure: same stimulus with out_ready=0 for 3 cycles after out_valid rises -> out_data holds 0x0004 and out_valid stays 1; after out_ready=1 the remaining words follow one per cycle.
- Overflow, DEPTH=4: out_ready=0, cap_en=1, PCs 0x0000..0x0006 on 7 consecutive edges -> fifo_level=4, overflow_cnt=2; release out_ready -> 5 records (PCs 0..4) stream back-to-back with no idle cycles.
- PC repeat: cap_en=1, currentAddress held at 0x0010 for 5 cycles -> exactly one record captured; change to 0x0012 -> second record captured.
- Mid-record reset: after w1 of a record is accepted, pulse RESET -> out_valid=0 immediately (asynchronous), fifo_level=0; the next capture restarts at w0.

Source files
------------

// File: rtl/cpu_trace_capture.sv
// Trace capture for the 16-bit CPU debug bus: packs instructions into records,
// buffers them in a FIFO and streams them out as words. Macro TRACE_TIMESTAMP_EN adds a cycle stamp word.
module cpu_trace_capture #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cap_en,
    input  logic [3:0]        op,
    input  logic [3:0]        rs,
    input  logic [3:0]        rt,
    input  logic [3:0]        rd,
    input  logic [15:0]       currentAddress,
    input  logic [15:0]       result,
    input  logic [15:0]       WriteData,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   fifo_level,
    output logic [7:0]        overflow_cnt
);

`ifdef TRACE_TIMESTAMP_EN
    localparam int NW = 5;
`else
    localparam int NW = 4;
`endif
    localparam int RW = 16 * NW;
    localparam logic [2:0] LAST = 3'(NW - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_d;
    logic [RW-1:0]     mem [DEPTH];
    logic [RW-1:0]     hold;
    logic [RW-1:0]     rec;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [2:0]        idx, idx_d;
    logic              first_flag;
    logic [15:0]       last_pc;
    logic              capture, full, empty, pop, push, drop;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) ts <= '0;
        else       ts <= ts + 16'd1;
    end

    assign rec = {ts, WriteData, result, op, rs, rt, rd, currentAddress};
`else
    assign rec = {WriteData, result, op, rs, rt, rd, currentAddress};
`endif

    assign capture = cap_en && (first_flag || currentAddress != last_pc);
    assign full    = count == (ADDR_W + 1)'(DEPTH);
    assign empty   = count == '0;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx != LAST) begin
                        idx_d = idx + 3'd1;
                    end else if (!empty) begin
                        pop   = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (pop) hold <= mem[rd_ptr];
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
            first_flag   <= 1'b1;
            last_pc      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
            if (cap_en) begin
                last_pc    <= currentAddress;
                first_flag <= 1'b0;
            end
        end
    end

    assign out_valid  = state == SEND;
    assign out_data   = out_valid ? 16'(hold >> {idx, 4'b0000}) : 16'h0000;
    assign out_last   = out_valid && idx == LAST;
    assign fifo_level = count;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed bench for cpu_trace_capture (DEPTH=4, default 4-word records).
module tb_cpu_trace_capture;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        cap_en = 1'b0;
    logic [3:0]  op = '0, rs = '0, rt = '0, rd = '0;
    logic [15:0] currentAddress = '0, result = '0, WriteData = '0;
    logic [15:0] out_data;
    logic        out_valid, out_ready = 1'b0, out_last;
    logic [2:0]  fifo_level;
    logic [7:0]  overflow_cnt;

    int total = 0;
    int bad = 0;

    cpu_trace_capture #(.DEPTH(4), .ADDR_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .cap_en(cap_en),
        .op(op), .rs(rs), .rt(rt), .rd(rd),
        .currentAddress(currentAddress), .result(result),
        .WriteData(WriteData), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .fifo_level(fifo_level),
        .overflow_cnt(overflow_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        cap_en = 1'b0;
        out_ready = 1'b0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    task automatic set_insn(input logic [15:0] pc);
        currentAddress = pc;
        op = 4'd1; rs = 4'd2; rt = 4'd3; rd = 4'd4;
        result = 16'h0007;
        WriteData = 16'h0007;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        cap_en = 1'b0;
        step();
        step();
        if ({out_valid, out_last} !== 2'b00 || fifo_level !== 3'd0 ||
            overflow_cnt !== 8'd0 || out_data !== 16'h0) begin
            $display("FAIL reset_outs got v=%b l=%b lvl=%0d ov=%0d d=%h want zeros",
                     out_valid, out_last, fifo_level, overflow_cnt, out_data);
            bad++;
        end
        total++;
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
                $display("FAIL reset_idle got v=%b lvl=%0d want 0 0",
                         out_valid, fifo_level);
                bad++;
            end
            total++;
        end
    endtask

    task automatic test_single();
        logic [15:0] exp_w [4];
        exp_w = '{16'h0004, 16'h1234, 16'h0007, 16'h0007};
        do_reset();
        out_ready = 1'b1;
        set_insn(16'h0004);
        cap_en = 1'b1;
        step();
        cap_en = 1'b0;
        if (out_valid !== 1'b0) begin
            $display("FAIL single_latency got v=%b want 0", out_valid);
            bad++;
        end
        total++;
        step();
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b1 || out_data !== exp_w[i] ||
                out_last !== (i == 3)) begin
                $display("FAIL single_w%0d got v=%b d=%h l=%b want 1 %h %b",
                         i, out_valid, out_data, out_last, exp_w[i], i == 3);
                bad++;
            end
            total++;
            step();
        end
        if (out_valid !== 1'b0) begin
            $display("FAIL single_end got v=%b want 0", out_valid);
            bad++;
        end
        total++;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_w [4];
        exp_w = '{16'h0004, 16'h1234, 16'h0007, 16'h0007};
        do_reset();
        set_insn(16'h0004);
        cap_en = 1'b1;
        step();
        cap_en = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b1 || out_data !== 16'h0004 || out_last !== 1'b0) begin
                $display("FAIL bp_hold%0d got v=%b d=%h l=%b want 1 0004 0",
                         i, out_valid, out_data, out_last);
                bad++;
            end
            total++;
            if (i < 3) step();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== exp_w[i] ||
                out_last !== (i == 3)) begin
                $display("FAIL bp_w%0d got v=%b d=%h l=%b want 1 %h %b",
                         i, out_valid, out_data, out_last, exp_w[i], i == 3);
                bad++;
            end
            total++;
        end
        step();
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_end got v=%b want 0", out_valid);
            bad++;
        end
        total++;
    endtask

    task automatic test_overflow();
        do_reset();
        set_insn(16'h0000);
        cap_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            currentAddress = 16'(i);
            step();
        end
        cap_en = 1'b0;
        if (fifo_level !== 3'd4 || overflow_cnt !== 8'd2) begin
            $display("FAIL ovf_counts got lvl=%0d ov=%0d want 4 2",
                     fifo_level, overflow_cnt);
            bad++;
        end
        total++;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_last !== (i % 4 == 3) ||
                (i % 4 == 0 && out_data !== 16'(i / 4))) begin
                $display("FAIL ovf_stream%0d got v=%b l=%b d=%h want 1 %b pc=%0d",
                         i, out_valid, out_last, out_data, i % 4 == 3, i / 4);
                bad++;
            end
            total++;
            step();
        end
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow_cnt !== 8'd2) begin
            $display("FAIL ovf_end got v=%b lvl=%0d ov=%0d want 0 0 2",
                     out_valid, fifo_level, overflow_cnt);
            bad++;
        end
        total++;
    endtask

    task automatic test_pc_repeat();
        do_reset();
        set_insn(16'h0010);
        cap_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        if (fifo_level !== 3'd0 || out_valid !== 1'b1 || out_data !== 16'h0010) begin
            $display("FAIL rep_one got lvl=%0d v=%b d=%h want 0 1 0010",
                     fifo_level, out_valid, out_data);
            bad++;
        end
        total++;
        currentAddress = 16'h0012;
        step();
        cap_en = 1'b0;
        if (fifo_level !== 3'd1) begin
            $display("FAIL rep_two got lvl=%0d want 1", fifo_level);
            bad++;
        end
        total++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        if (out_valid !== 1'b1 || out_data !== 16'h0012 || fifo_level !== 3'd0) begin
            $display("FAIL rep_second got v=%b d=%h lvl=%0d want 1 0012 0",
                     out_valid, out_data, fifo_level);
            bad++;
        end
        total++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b1;
        set_insn(16'h0020);
        cap_en = 1'b1;
        step();
        currentAddress = 16'h0022;
        step();
        cap_en = 1'b0;
        step();
        step();
        if (out_data !== 16'h0007 || fifo_level !== 3'd1) begin
            $display("FAIL mid_pre got d=%h lvl=%0d want 0007 1",
                     out_data, fifo_level);
            bad++;
        end
        total++;
        RESET = 1'b1;
        #1;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_last !== 1'b0) begin
            $display("FAIL mid_async got v=%b lvl=%0d l=%b want 0 0 0",
                     out_valid, fifo_level, out_last);
            bad++;
        end
        total++;
        #2;
        RESET = 1'b0;
        step();
        set_insn(16'h0030);
        cap_en = 1'b1;
        step();
        cap_en = 1'b0;
        step();
        if (out_valid !== 1'b1 || out_data !== 16'h0030 || out_last !== 1'b0) begin
            $display("FAIL mid_restart got v=%b d=%h l=%b want 1 0030 0",
                     out_valid, out_data, out_last);
            bad++;
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_pc_repeat();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
